// File: rtl/vib_dect_pkg.sv
// Shared types and helpers for the vibrate_dect chain.
// Offset-binary conversion is shared with alarm_judge thresholds.
package vib_dect_pkg;

  localparam int VIB_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    TRACK
  } state_e;

  function automatic logic [VIB_DW-1:0] to_offset_bin(
    input logic [VIB_DW-1:0] x
  );
    return x ^ {1'b1, {(VIB_DW-1){1'b0}}};
  endfunction

endpackage

// File: rtl/peak_strobe_gen.sv
// Window-done strobe: load/decrement counter, high while non-zero.
// The strobe always runs to completion once loaded.
module peak_strobe_gen #(
  parameter int STROBE_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic strobe
);

  localparam int CW = $clog2(STROBE_W + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload on window close, else count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(STROBE_W);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Strobe counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign strobe = (cnt_q != '0);

endmodule

// File: rtl/peak_window_tracker.sv
// Running max/min of ADC samples over fixed windows of WIN_LEN samples.
// Define PEAK_TRACK_SIGNED_EN for two's-complement sample input.
module peak_window_tracker
  import vib_dect_pkg::*;
#(
  parameter int DW       = VIB_DW,
  parameter int WIN_LEN  = 256,
  parameter int STROBE_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] sample,
  input  logic          sample_vld,
  output logic [DW-1:0] dat_max,
  output logic [DW-1:0] dat_min,
  output logic          dat_limit_en,
  output logic          busy
);

  if (WIN_LEN < 2 || WIN_LEN > 65535 || WIN_LEN < STROBE_W + 1
      || STROBE_W < 1) begin : g_bad_cfg
    $error("peak_window_tracker: illegal WIN_LEN/STROBE_W");
  end

  localparam logic [15:0] LAST = 16'(WIN_LEN - 1);

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [DW-1:0] run_max_q, run_max_d;
  logic [DW-1:0] run_min_q, run_min_d;
  logic [DW-1:0] dat_max_q, dat_max_d;
  logic [DW-1:0] dat_min_q, dat_min_d;
  logic [DW-1:0] samp_c;
  logic [DW-1:0] nxt_max, nxt_min;
  logic          load;

`ifdef PEAK_TRACK_SIGNED_EN
  // Flip the sign bit so unsigned compares order signed values.
  assign samp_c = sample ^ {1'b1, {(DW-1){1'b0}}};
`else
  assign samp_c = sample;
`endif

  // FSM next state, window counter and min/max datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    dat_max_d = dat_max_q;
    dat_min_d = dat_min_q;
    load      = 1'b0;
    nxt_max   = (samp_c > run_max_q) ? samp_c : run_max_q;
    nxt_min   = (samp_c < run_min_q) ? samp_c : run_min_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = FIRST;
        FIRST: begin
          if (sample_vld) begin
            run_max_d = samp_c;
            run_min_d = samp_c;
            cnt_d     = 16'd1;
            state_d   = TRACK;
          end
        end
        TRACK: begin
          if (sample_vld) begin
            if (cnt_q == LAST) begin
              dat_max_d = nxt_max;
              dat_min_d = nxt_min;
              load      = 1'b1;
              cnt_d     = '0;
              state_d   = FIRST;
            end else begin
              run_max_d = nxt_max;
              run_min_d = nxt_min;
              cnt_d     = cnt_q + 16'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counter and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      run_max_q <= '0;
      run_min_q <= '0;
      dat_max_q <= '0;
      dat_min_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      dat_max_q <= dat_max_d;
      dat_min_q <= dat_min_d;
    end
  end

  peak_strobe_gen #(
    .STROBE_W(STROBE_W)
  ) u_strobe (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .strobe(dat_limit_en)
  );

  assign dat_max = dat_max_q;
  assign dat_min = dat_min_q;
  assign busy    = (state_q == TRACK);

endmodule
